// File: rtl/front_panel_switches_pkg.sv
// Shared widths, key bit indices, display-select reset value and command FSM
// states for the PDP-8/e front-panel input block.
package front_panel_switches_pkg;

  localparam int unsigned SR_W   = 12;
  localparam int unsigned N_KEYS = 6;
  localparam int unsigned DSEL_W = 6;

  // Key order matches raw_btn / cmd (index 0 is leftmost on the panel).
  localparam int unsigned KEY_ADDR_LOAD      = 0;
  localparam int unsigned KEY_EXTD_ADDR_LOAD = 1;
  localparam int unsigned KEY_CLEAR          = 2;
  localparam int unsigned KEY_CONT           = 3;
  localparam int unsigned KEY_EXAM           = 4;
  localparam int unsigned KEY_DEP            = 5;

  localparam logic [DSEL_W-1:0] DSEL_RESET = 6'b100000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } cmd_state_e;

  function automatic logic [0:N_KEYS-1] first_key(input logic [0:N_KEYS-1] keys);
    logic [0:N_KEYS-1] onehot;
    logic              found;
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (keys[i] && !found) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/front_panel_switches_if.sv
// Panel-side bundle: raw switch/key inputs and the cleaned-up signals the CPU side consumes.
interface front_panel_switches_if;

  logic [0:front_panel_switches_pkg::SR_W-1]   raw_sr;
  logic                                        raw_halt;
  logic                                        raw_sstep;
  logic [0:front_panel_switches_pkg::N_KEYS-1] raw_btn;
  logic                                        raw_dsel_btn;

  logic [0:front_panel_switches_pkg::SR_W-1]   sr;
  logic                                        halt_sw;
  logic                                        sstep_sw;
  logic [0:front_panel_switches_pkg::N_KEYS-1] cmd;
  logic [front_panel_switches_pkg::DSEL_W-1:0] dsel;
  logic                                        sw_active;

  modport master (
    output raw_sr, raw_halt, raw_sstep, raw_btn, raw_dsel_btn,
    input  sr, halt_sw, sstep_sw, cmd, dsel, sw_active
  );

  modport slave (
    input  raw_sr, raw_halt, raw_sstep, raw_btn, raw_dsel_btn,
    output sr, halt_sw, sstep_sw, cmd, dsel, sw_active
  );

endinterface

// File: rtl/front_panel_switches_sw_debounce.sv
// One-bit 2-flop synchroniser followed by a debouncer: the stable value flips only
// after the synced input has disagreed with it for DEBOUNCE_CYCLES+1 consecutive cycles.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned    CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/front_panel_switches.sv
// PDP-8/e front-panel input block: debounced switch levels, one-shot command
// pulses with key lockout, and the display-select rotator.
//
// state   | meaning
// ST_IDLE | no key accepted; next stable press emits a cmd pulse
// ST_HELD | a key was accepted; wait for all keys released (sw_active high)
module front_panel_switches
  import front_panel_switches_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  front_panel_switches_if.slave pnl
);

  logic [0:SR_W-1]   sr_stable;
  logic              halt_stable;
  logic              sstep_stable;
  logic [0:N_KEYS-1] key_stable;
  logic              dsel_key_stable;

  for (genvar gi = 0; gi < int'(SR_W); gi++) begin : g_sr
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (pnl.raw_sr[gi]),
      .stable_o (sr_stable[gi])
    );
  end

  for (genvar gk = 0; gk < int'(N_KEYS); gk++) begin : g_key
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (pnl.raw_btn[gk]),
      .stable_o (key_stable[gk])
    );
  end

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (pnl.raw_halt),
    .stable_o (halt_stable)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sstep (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (pnl.raw_sstep),
    .stable_o (sstep_stable)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dsel (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (pnl.raw_dsel_btn),
    .stable_o (dsel_key_stable)
  );

  cmd_state_e        state_q, state_d;
  logic [0:N_KEYS-1] cmd_q, cmd_d;

  // Only the lowest-index key of the accepting press is ever reported.
  always_comb begin
    state_d = state_q;
    cmd_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|key_stable) begin
          cmd_d   = first_key(key_stable);
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!(|key_stable)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  logic              dsel_key_prev_q;
  logic [DSEL_W-1:0] dsel_q, dsel_d;
  logic              dsel_rise;

  assign dsel_rise = dsel_key_stable & ~dsel_key_prev_q;

  always_comb begin
    dsel_d = dsel_q;
    if (dsel_rise) begin
      dsel_d = {dsel_q[0], dsel_q[DSEL_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dsel_key_prev_q <= 1'b0;
      dsel_q          <= DSEL_RESET;
    end else begin
      dsel_key_prev_q <= dsel_key_stable;
      dsel_q          <= dsel_d;
    end
  end

  assign pnl.sr        = sr_stable;
  assign pnl.halt_sw   = halt_stable;
  assign pnl.sstep_sw  = sstep_stable;
  assign pnl.cmd       = cmd_q;
  assign pnl.dsel      = dsel_q;
  assign pnl.sw_active = (state_q == ST_HELD);

endmodule

// File: tb/tb_front_panel_switches.sv
// Bench for front_panel_switches: directed panel scenarios plus random toggling,
// checked every cycle against a sliding-window behavioural model.
module tb_front_panel_switches;
  import front_panel_switches_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  front_panel_switches_if pnl();

  front_panel_switches #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .pnl   (pnl)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: bit b of a 21-bit vector = sr[0..11], halt, sstep, keys[0..5], dsel key.
  logic [20:0] prev_raw;
  logic [20:0] syn_hist[$];
  logic [20:0] m_stable, m_stable_old;
  int          m_dsel_idx;
  bit          m_locked;
  logic [0:5]  m_cmd;

  function automatic logic [20:0] pack_raw();
    logic [20:0] v;
    for (int i = 0; i < 12; i++) v[i] = pnl.raw_sr[i];
    v[12] = pnl.raw_halt;
    v[13] = pnl.raw_sstep;
    for (int j = 0; j < 6; j++) v[14+j] = pnl.raw_btn[j];
    v[20] = pnl.raw_dsel_btn;
    return v;
  endfunction

  task automatic model_reset();
    prev_raw = '0;
    syn_hist.delete();
    for (int i = 0; i <= D; i++) syn_hist.push_back('0);
    m_stable     = '0;
    m_stable_old = '0;
    m_dsel_idx   = 0;
    m_locked     = 0;
    m_cmd        = '0;
  endtask

  task automatic model_edge();
    logic [20:0] nxt;
    bit          any_key;
    bit          all_other;
    m_cmd   = '0;
    any_key = 0;
    for (int j = 0; j < 6; j++) if (m_stable[14+j]) any_key = 1;
    if (!m_locked && any_key) begin
      for (int j = 5; j >= 0; j--) if (m_stable[14+j]) m_cmd = 6'b100000 >> j;
      m_locked = 1;
    end else if (m_locked && !any_key) begin
      m_locked = 0;
    end
    if (m_stable[20] && !m_stable_old[20]) m_dsel_idx = (m_dsel_idx + 1) % 6;
    // A stable bit flips once the last D+1 synced samples all disagree with it.
    nxt = m_stable;
    for (int b = 0; b < 21; b++) begin
      all_other = 1;
      foreach (syn_hist[h]) if (syn_hist[h][b] == m_stable[b]) all_other = 0;
      if (all_other) nxt[b] = ~m_stable[b];
    end
    m_stable_old = m_stable;
    m_stable     = nxt;
    void'(syn_hist.pop_front());
    syn_hist.push_back(prev_raw);
    prev_raw = pack_raw();
  endtask

  task automatic tick();
    logic [0:11] e_sr;
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    for (int i = 0; i < 12; i++) e_sr[i] = m_stable[i];
    check("sr",        pnl.sr,        e_sr);
    check("halt_sw",   pnl.halt_sw,   m_stable[12]);
    check("sstep_sw",  pnl.sstep_sw,  m_stable[13]);
    check("cmd",       pnl.cmd,       m_cmd);
    check("sw_active", pnl.sw_active, m_locked);
    check("dsel",      pnl.dsel,      6'b100000 >> m_dsel_idx);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_inputs();
    pnl.raw_sr       = '0;
    pnl.raw_halt     = 1'b0;
    pnl.raw_sstep    = 1'b0;
    pnl.raw_btn      = '0;
    pnl.raw_dsel_btn = 1'b0;
  endtask

  logic [5:0] dsel_seq[7];

  initial begin
    dsel_seq = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b100000, 6'b010000};
    reset = 1'b0;
    zero_inputs();
    model_reset();

    // Reset held with random inputs, then released.
    pnl.raw_sr       = 12'($urandom);
    pnl.raw_halt     = 1'($urandom);
    pnl.raw_sstep    = 1'($urandom);
    pnl.raw_btn      = 6'($urandom);
    pnl.raw_dsel_btn = 1'($urandom);
    ticks(3);
    check("rst_sr",   pnl.sr, 12'o0000);
    check("rst_cmd",  pnl.cmd, 6'b000000);
    check("rst_act",  pnl.sw_active, 1'b0);
    check("rst_dsel", pnl.dsel, 6'b100000);
    reset = 1'b1;
    ticks(5);
    check("rel_sr_hold",   pnl.sr, 12'o0000);
    check("rel_dsel_hold", pnl.dsel, 6'b100000);
    ticks(20);
    zero_inputs();
    ticks(20);
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // Switch register debounce and a short glitch.
    pnl.raw_sr = 12'o5252;
    ticks(6);
    check("sr_early", pnl.sr, 12'o0000);
    ticks(1);
    check("sr_5252", pnl.sr, 12'o5252);
    pnl.raw_sr[0] = 1'b0;
    ticks(3);
    pnl.raw_sr[0] = 1'b1;
    ticks(10);
    check("sr_glitch", pnl.sr, 12'o5252);

    // Single EXAM press.
    pnl.raw_btn = 6'b000010;
    ticks(7);
    check("exam_early", pnl.cmd, 6'b000000);
    ticks(1);
    check("exam_cmd", pnl.cmd, 6'b000010);
    check("exam_act", pnl.sw_active, 1'b1);
    ticks(12);
    pnl.raw_btn = '0;
    ticks(10);
    check("exam_rel", pnl.sw_active, 1'b0);

    // Priority and lockout.
    pnl.raw_btn = 6'b000101;
    ticks(8);
    check("prio_cont", pnl.cmd, 6'b000100);
    ticks(5);
    pnl.raw_btn[0] = 1'b1;
    ticks(10);
    check("lock_act", pnl.sw_active, 1'b1);
    pnl.raw_btn = '0;
    ticks(10);
    pnl.raw_btn = 6'b000001;
    ticks(8);
    check("dep_cmd", pnl.cmd, 6'b000001);
    pnl.raw_btn = '0;
    ticks(10);

    // Display select wraps around.
    for (int p = 0; p < 7; p++) begin
      pnl.raw_dsel_btn = 1'b1;
      ticks(10);
      check($sformatf("dsel_%0d", p), pnl.dsel, dsel_seq[p]);
      pnl.raw_dsel_btn = 1'b0;
      ticks(10);
    end

    // Reset while CLEAR is held; the held key is accepted afresh afterwards.
    pnl.raw_btn = 6'b001000;
    ticks(8);
    check("clr_cmd", pnl.cmd, 6'b001000);
    ticks(4);
    reset = 1'b0;
    #1;
    check("mid_rst_act",  pnl.sw_active, 1'b0);
    check("mid_rst_cmd",  pnl.cmd, 6'b000000);
    check("mid_rst_dsel", pnl.dsel, 6'b100000);
    ticks(3);
    reset = 1'b1;
    ticks(7);
    check("clr_again_early", pnl.cmd, 6'b000000);
    ticks(1);
    check("clr_again_cmd", pnl.cmd, 6'b001000);
    check("clr_again_act", pnl.sw_active, 1'b1);
    pnl.raw_btn = '0;
    ticks(10);

    // Random slow toggling of individual inputs.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int b;
        b = $urandom_range(0, 20);
        if (b < 12) pnl.raw_sr[b] = ~pnl.raw_sr[b];
        else if (b == 12) pnl.raw_halt = ~pnl.raw_halt;
        else if (b == 13) pnl.raw_sstep = ~pnl.raw_sstep;
        else if (b < 20) pnl.raw_btn[b-14] = ~pnl.raw_btn[b-14];
        else pnl.raw_dsel_btn = ~pnl.raw_dsel_btn;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
